// File: rtl/alu_ctrl_pkg.sv
// ============================================================================
// Module : alu_ctrl_pkg
// Brief  : Shared opcode constants, dispatch-state encoding, writeback grant
//          indices and result-word width helper for the ALU op scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu_ctrl_pkg;

  // Opcodes as presented at the input FIFO head.
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MUL  = 2'b10;
  localparam logic [1:0] OP_RSVD = 2'b11;

  // Dispatch FSM states.
  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_MUL  = 2'd1,
    D_ALU  = 2'd2,
    D_DROP = 2'd3
  } disp_state_e;

  // Bit positions of the two requesters in the writeback grant vector.
  localparam int unsigned GNT_MUL = 0;
  localparam int unsigned GNT_ALU = 1;

  // Result word is {id, flag, data}.
  function automatic int unsigned res_width(input int unsigned data_size,
                                            input int unsigned id_size);
    return data_size + 1 + id_size;
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_rr_arbiter.sv
// ============================================================================
// Module : wb_rr_arbiter
// Brief  : Two-requester round-robin arbiter for the output-FIFO write port.
//          Grant is combinational; the last-granted pointer is registered.
// Ports  : clk   in   clock
//          rst   in   synchronous active-high reset (pointer -> ALU)
//          full  in   output FIFO full; suppresses every grant
//          req   in   [1:0] request vector {alu, mul}
//          gnt   out  [1:0] one-hot (or zero) grant vector {alu, mul}
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_rr_arbiter
  import alu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       full,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // 1 = ALU was granted last, 0 = MUL was granted last.
  logic last_alu_q;
  logic last_alu_d;

  always_comb begin
    gnt        = 2'b00;
    last_alu_d = last_alu_q;
    if (!full) begin
      unique case (req)
        2'b01:   gnt[GNT_MUL] = 1'b1;
        2'b10:   gnt[GNT_ALU] = 1'b1;
        // Tie: whoever did not win last time goes now.
        2'b11: begin
          if (last_alu_q) gnt[GNT_MUL] = 1'b1;
          else            gnt[GNT_ALU] = 1'b1;
        end
        default: gnt = 2'b00;
      endcase
    end
    if (gnt != 2'b00) last_alu_d = gnt[GNT_ALU];
  end

  always_ff @(posedge clk) begin
    if (rst) last_alu_q <= 1'b1;
    else     last_alu_q <= last_alu_d;
  end

endmodule

`default_nettype wire

// File: rtl/alu_op_scheduler.sv
// ============================================================================
// Module : alu_op_scheduler
// Brief  : In-order dispatcher from the ALU input FIFO to the multiplier and
//          add/sub unit, plus round-robin writeback of their results into the
//          output FIFO.
// Ports  : clk, rst                       clock, sync active-high reset
//          in_empty, in_op, in_rd_en      input FIFO head / pop
//          mul_go, mul_ready, mul_accept  multiplier dispatch handshake
//          alu_go, alu_accept             add/sub dispatch handshake
//          mul_valid_res, mul_result,
//          mul_written                    multiplier result writeback
//          alu_valid_res, alu_result,
//          alu_written                    add/sub result writeback
//          out_full, out_wr_en, out_data  output FIFO write port
//          op_err                         reserved opcode dropped
//          mul_cnt, alu_cnt, drop_cnt     saturating statistics counters,
//                                         present only with ALU_SCHED_STATS_EN
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_op_scheduler
  import alu_ctrl_pkg::*;
#(
  parameter  int unsigned DATA_SIZE = 16,
  parameter  int unsigned ID_SIZE   = 8,
  localparam int unsigned RES_W     = res_width(DATA_SIZE, ID_SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_empty,
  input  logic [1:0]       in_op,
  output logic             in_rd_en,
  output logic             mul_go,
  input  logic             mul_ready,
  input  logic             mul_accept,
  output logic             alu_go,
  input  logic             alu_accept,
  input  logic             mul_valid_res,
  input  logic [RES_W-1:0] mul_result,
  output logic             mul_written,
  input  logic             alu_valid_res,
  input  logic [RES_W-1:0] alu_result,
  output logic             alu_written,
  input  logic             out_full,
  output logic             out_wr_en,
  output logic [RES_W-1:0] out_data,
`ifdef ALU_SCHED_STATS_EN
  output logic [15:0]      mul_cnt,
  output logic [15:0]      alu_cnt,
  output logic [15:0]      drop_cnt,
`endif
  output logic             op_err
);

  // --------------------------------------------------------------------------
  // Dispatch FSM
  // --------------------------------------------------------------------------
  disp_state_e state_q;
  disp_state_e state_d;

  logic pop;
  logic mul_req;
  logic alu_req;
  logic drop;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    mul_req = 1'b0;
    alu_req = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      D_IDLE: begin
        if (!in_empty) begin
          unique case (in_op)
            OP_MUL:  state_d = D_MUL;
            OP_RSVD: state_d = D_DROP;
            default: state_d = D_ALU;
          endcase
        end
      end
      D_MUL: begin
        // Drop the request in the accept cycle so the unit never sees a
        // second start for the same operation.
        mul_req = mul_ready & ~mul_accept;
        if (mul_accept) begin
          pop     = 1'b1;
          state_d = D_IDLE;
        end
      end
      D_ALU: begin
        alu_req = ~alu_accept;
        if (alu_accept) begin
          pop     = 1'b1;
          state_d = D_IDLE;
        end
      end
      D_DROP: begin
        pop     = 1'b1;
        drop    = 1'b1;
        state_d = D_IDLE;
      end
      default: state_d = D_IDLE;
    endcase
  end

  // Aborting to D_IDLE without a pop leaves the head entry in the FIFO, so it
  // is simply dispatched again once reset is released.
  always_ff @(posedge clk) begin
    if (rst) state_q <= D_IDLE;
    else     state_q <= state_d;
  end

  // --------------------------------------------------------------------------
  // Writeback arbitration
  // --------------------------------------------------------------------------
  logic [1:0] req;
  logic [1:0] gnt;
  logic       gnt_mul;
  logic       gnt_alu;

  assign req[GNT_MUL] = mul_valid_res;
  assign req[GNT_ALU] = alu_valid_res;

  wb_rr_arbiter u_wb_arb (
    .clk  (clk),
    .rst  (rst),
    .full (out_full),
    .req  (req),
    .gnt  (gnt)
  );

  // Outputs are forced low for the whole reset cycle, not only after the edge.
  assign gnt_mul = gnt[GNT_MUL] & ~rst;
  assign gnt_alu = gnt[GNT_ALU] & ~rst;

  assign mul_written = gnt_mul;
  assign alu_written = gnt_alu;
  assign out_wr_en   = gnt_mul | gnt_alu;
  assign out_data    = gnt_mul ? mul_result :
                       gnt_alu ? alu_result : '0;

  assign in_rd_en = pop     & ~rst;
  assign mul_go   = mul_req & ~rst;
  assign alu_go   = alu_req & ~rst;
  assign op_err   = drop    & ~rst;

  // --------------------------------------------------------------------------
  // Optional statistics
  // --------------------------------------------------------------------------
`ifdef ALU_SCHED_STATS_EN
  logic [15:0] mul_cnt_q;
  logic [15:0] alu_cnt_q;
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_cnt_q  <= 16'd0;
      alu_cnt_q  <= 16'd0;
      drop_cnt_q <= 16'd0;
    end else begin
      if (mul_written && (mul_cnt_q != 16'hFFFF))  mul_cnt_q  <= mul_cnt_q + 16'd1;
      if (alu_written && (alu_cnt_q != 16'hFFFF))  alu_cnt_q  <= alu_cnt_q + 16'd1;
      if (op_err      && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign mul_cnt  = mul_cnt_q;
  assign alu_cnt  = alu_cnt_q;
  assign drop_cnt = drop_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_op_scheduler.sv
// ============================================================================
// Module : tb_alu_op_scheduler
// Brief  : Directed self-checking bench for alu_op_scheduler. Expected output
//          FIFO writes are queued as stimulus is driven and compared by a
//          negedge monitor when the DUT writes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_op_scheduler;

  localparam int unsigned RES_W = 25;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_empty;
  logic [1:0]       in_op;
  logic             in_rd_en;
  logic             mul_go;
  logic             mul_ready;
  logic             mul_accept;
  logic             alu_go;
  logic             alu_accept;
  logic             mul_valid_res;
  logic [RES_W-1:0] mul_result;
  logic             mul_written;
  logic             alu_valid_res;
  logic [RES_W-1:0] alu_result;
  logic             alu_written;
  logic             out_full;
  logic             out_wr_en;
  logic [RES_W-1:0] out_data;
  logic             op_err;
`ifdef ALU_SCHED_STATS_EN
  logic [15:0]      mul_cnt;
  logic [15:0]      alu_cnt;
  logic [15:0]      drop_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic             mw;
    logic             aw;
    logic [RES_W-1:0] data;
  } wr_t;

  wr_t exp_q[$];

  always #5 clk = ~clk;

  alu_op_scheduler dut (
    .clk           (clk),
    .rst           (rst),
    .in_empty      (in_empty),
    .in_op         (in_op),
    .in_rd_en      (in_rd_en),
    .mul_go        (mul_go),
    .mul_ready     (mul_ready),
    .mul_accept    (mul_accept),
    .alu_go        (alu_go),
    .alu_accept    (alu_accept),
    .mul_valid_res (mul_valid_res),
    .mul_result    (mul_result),
    .mul_written   (mul_written),
    .alu_valid_res (alu_valid_res),
    .alu_result    (alu_result),
    .alu_written   (alu_written),
    .out_full      (out_full),
    .out_wr_en     (out_wr_en),
    .out_data      (out_data),
`ifdef ALU_SCHED_STATS_EN
    .mul_cnt       (mul_cnt),
    .alu_cnt       (alu_cnt),
    .drop_cnt      (drop_cnt),
`endif
    .op_err        (op_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Move to the sampling point; the monitor has already run at the negedge.
  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic mw, input logic aw, input logic [RES_W-1:0] d);
    exp_q.push_back('{mw: mw, aw: aw, data: d});
  endtask

  // Scoreboard: every write must match the oldest queued expectation.
  always @(negedge clk) begin
    if (out_wr_en || mul_written || alu_written) begin
      chk("spurious_write", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_en",       32'(out_wr_en),   32'd1);
        chk("mul_written", 32'(mul_written), 32'(e.mw));
        chk("alu_written", 32'(alu_written), 32'(e.aw));
        chk("out_data",    32'(out_data),    32'(e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    in_empty      = 1'b1;
    in_op         = 2'b00;
    mul_ready     = 1'b0;
    mul_accept    = 1'b0;
    alu_accept    = 1'b0;
    mul_valid_res = 1'b0;
    mul_result    = '0;
    alu_valid_res = 1'b0;
    alu_result    = '0;
    out_full      = 1'b0;
    cyc();
    cyc();

    // ---- Reset: requests present but every output must stay low ----------
    in_empty = 1'b0; in_op = 2'b10; mul_ready = 1'b1;
    mul_valid_res = 1'b1; alu_valid_res = 1'b1;
    mul_result = 25'h0A0001; alu_result = 25'h0B0001;
    settle();
    chk("rst_mul_go",    32'(mul_go),    32'd0);
    chk("rst_alu_go",    32'(alu_go),    32'd0);
    chk("rst_in_rd_en",  32'(in_rd_en),  32'd0);
    chk("rst_op_err",    32'(op_err),    32'd0);
    chk("rst_out_wr_en", 32'(out_wr_en), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    cyc();

    // ---- Contention: MUL, ALU, MUL ----------------------------------------
    rst = 1'b0; in_empty = 1'b1; mul_ready = 1'b0;
    mul_result = 25'h0A0011; alu_result = 25'h0B0011;
    expect_wr(1'b1, 1'b0, 25'h0A0011);
    settle();
    chk("cont1_done", 32'(exp_q.size()), 32'd0);
    cyc();
    mul_result = 25'h0A0022; alu_result = 25'h0B0022;
    expect_wr(1'b0, 1'b1, 25'h0B0022);
    settle();
    chk("cont2_done", 32'(exp_q.size()), 32'd0);
    cyc();
    mul_result = 25'h0A0033; alu_result = 25'h0B0033;
    expect_wr(1'b1, 1'b0, 25'h0A0033);
    settle();
    chk("cont3_done", 32'(exp_q.size()), 32'd0);
    cyc();
    mul_valid_res = 1'b0; alu_valid_res = 1'b0;
    settle();
    chk("idle_wr_en", 32'(out_wr_en), 32'd0);
    chk("idle_data",  32'(out_data),  32'd0);

    // ---- Backpressure ------------------------------------------------------
    for (int i = 0; i < 4; i++) begin
      cyc();
      out_full = 1'b1; mul_valid_res = 1'b1; mul_result = 25'h1C0DE5;
      settle();
      chk("bp_wr_en",       32'(out_wr_en),   32'd0);
      chk("bp_mul_written", 32'(mul_written), 32'd0);
    end
    cyc();
    out_full = 1'b0;
    expect_wr(1'b1, 1'b0, 25'h1C0DE5);
    settle();
    chk("bp_release", 32'(exp_q.size()), 32'd0);
    cyc();
    mul_valid_res = 1'b0;
    alu_valid_res = 1'b1; alu_result = 25'h155AA5;
    expect_wr(1'b0, 1'b1, 25'h155AA5);
    settle();
    chk("alu_only", 32'(exp_q.size()), 32'd0);

    // ---- MUL dispatch, with a concurrent ALU write on the pop cycle -------
    cyc();
    alu_valid_res = 1'b0;
    in_empty = 1'b0; in_op = 2'b10; mul_ready = 1'b1;
    settle();
    chk("mul_c1_go", 32'(mul_go), 32'd0);
    cyc();
    settle();
    chk("mul_c2_go", 32'(mul_go),   32'd1);
    chk("mul_c2_rd", 32'(in_rd_en), 32'd0);
    cyc();
    mul_accept = 1'b1;
    alu_valid_res = 1'b1; alu_result = 25'h0F00F6;
    expect_wr(1'b0, 1'b1, 25'h0F00F6);
    settle();
    chk("mul_c3_go", 32'(mul_go),        32'd0);
    chk("mul_c3_rd", 32'(in_rd_en),      32'd1);
    chk("mul_c3_wr", 32'(exp_q.size()),  32'd0);
    cyc();
    mul_accept = 1'b0; alu_valid_res = 1'b0; in_empty = 1'b1;
    settle();
    chk("mul_c4_go", 32'(mul_go),   32'd0);
    chk("mul_c4_rd", 32'(in_rd_en), 32'd0);

    // ---- Reserved opcode ---------------------------------------------------
    cyc();
    in_empty = 1'b0; in_op = 2'b11;
    settle();
    chk("drop_c1_err", 32'(op_err), 32'd0);
    cyc();
    settle();
    chk("drop_err",    32'(op_err),   32'd1);
    chk("drop_rd",     32'(in_rd_en), 32'd1);
    chk("drop_mul_go", 32'(mul_go),   32'd0);
    chk("drop_alu_go", 32'(alu_go),   32'd0);
    cyc();
    in_empty = 1'b1;
    settle();
    chk("drop_after_err", 32'(op_err),   32'd0);
    chk("drop_after_rd",  32'(in_rd_en), 32'd0);
`ifdef ALU_SCHED_STATS_EN
    chk("drop_cnt", 32'(drop_cnt), 32'd1);
    chk("mul_cnt",  32'(mul_cnt),  32'd3);
    chk("alu_cnt",  32'(alu_cnt),  32'd3);
`endif

    // ---- Stray accept in D_IDLE is ignored --------------------------------
    cyc();
    alu_accept = 1'b1;
    settle();
    chk("stray_idle_rd", 32'(in_rd_en), 32'd0);

    // ---- SUB dispatch with a stray mul_accept while in D_ALU --------------
    cyc();
    alu_accept = 1'b0; in_empty = 1'b0; in_op = 2'b01;
    settle();
    chk("sub_c1_go", 32'(alu_go), 32'd0);
    cyc();
    settle();
    chk("sub_c2_go", 32'(alu_go),   32'd1);
    chk("sub_c2_rd", 32'(in_rd_en), 32'd0);
    cyc();
    mul_accept = 1'b1;
    settle();
    chk("sub_stray_rd", 32'(in_rd_en), 32'd0);
    chk("sub_stray_go", 32'(alu_go),   32'd1);
    cyc();
    mul_accept = 1'b0; alu_accept = 1'b1;
    settle();
    chk("sub_acc_go", 32'(alu_go),   32'd0);
    chk("sub_acc_rd", 32'(in_rd_en), 32'd1);
    cyc();
    alu_accept = 1'b0; in_empty = 1'b1;
    settle();
    chk("sub_done_rd", 32'(in_rd_en), 32'd0);

    // ---- Head-of-line blocking: MUL stalled, ADD behind it -----------------
    cyc();
    in_empty = 1'b0; in_op = 2'b10; mul_ready = 1'b0;
    settle();
    for (int i = 0; i < 10; i++) begin
      cyc();
      settle();
      chk("hol_alu_go", 32'(alu_go),   32'd0);
      chk("hol_mul_go", 32'(mul_go),   32'd0);
      chk("hol_rd",     32'(in_rd_en), 32'd0);
    end
    cyc();
    mul_ready = 1'b1;
    settle();
    chk("hol_ready_go", 32'(mul_go), 32'd1);
    cyc();
    mul_accept = 1'b1;
    settle();
    chk("hol_acc_rd",     32'(in_rd_en), 32'd1);
    chk("hol_acc_alu_go", 32'(alu_go),   32'd0);
    cyc();
    mul_accept = 1'b0; in_op = 2'b00;
    settle();
    chk("hol_add_idle", 32'(alu_go), 32'd0);
    cyc();
    settle();
    chk("hol_add_go", 32'(alu_go), 32'd1);

    // ---- Reset mid-dispatch (in D_ALU, before accept) ----------------------
    cyc();
    rst = 1'b1;
    settle();
    chk("midrst_alu_go", 32'(alu_go),   32'd0);
    chk("midrst_rd",     32'(in_rd_en), 32'd0);
    chk("midrst_mul_go", 32'(mul_go),   32'd0);
    cyc();
    rst = 1'b0;
    settle();
    chk("redisp_idle_go", 32'(alu_go),   32'd0);
    chk("redisp_idle_rd", 32'(in_rd_en), 32'd0);
    cyc();
    settle();
    chk("redisp_go", 32'(alu_go), 32'd1);
    cyc();
    alu_accept = 1'b1;
    settle();
    chk("redisp_rd", 32'(in_rd_en), 32'd1);
    cyc();
    alu_accept = 1'b0; in_empty = 1'b1; mul_ready = 1'b0;
    settle();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_op_scheduler.md
Name: alu_op_scheduler

Overview:
- Sits between the ALU input FIFO, the shift-and-add multiplier, the single-cycle add/sub unit and the ALU output FIFO.
- Pops operations in order and dispatches each to the correct unit, using a valid/accept handshake per unit.
- Arbitrates round-robin between the two units' finished results for the single output-FIFO write port, and returns the per-unit "written" acknowledge.

Parameters:
- DATA_SIZE, 16, full result data width; multiplier operands are DATA_SIZE/2.
- ID_SIZE, 8, width of the operation tag.
- RES_W, DATA_SIZE+1+ID_SIZE, result word width: {id, flag, data}. Derived; never overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_empty  in  1  input FIFO empty.
- in_op  in  2  opcode at the input FIFO head.
- in_rd_en  out  1  pop input FIFO (1-cycle pulse).
- mul_go  out  1  drives the multiplier's m_valid_data.
- mul_ready  in  1  multiplier idle and able to start (m_ready_data).
- mul_accept  in  1  multiplier has latched its operands (1-cycle pulse).
- alu_go  out  1  add/sub unit request.
- alu_accept  in  1  add/sub unit has latched its operands (1-cycle pulse).
- mul_valid_res  in  1  multiplier result pending.
- mul_result  in  RES_W  multiplier result word.
- mul_written  out  1  multiplier result written to the output FIFO.
- alu_valid_res  in  1  add/sub result pending.
- alu_result  in  RES_W  add/sub result word.
- alu_written  out  1  add/sub result written to the output FIFO.
- out_full  in  1  output FIFO full.
- out_wr_en  out  1  output FIFO write.
- out_data  out  RES_W  output FIFO write data.
- op_err  out  1  reserved opcode dropped (1-cycle pulse).

Behaviour:
- Opcodes: 00 ADD, 01 SUB, 10 MUL, 11 reserved.
- One clock domain; every register resets synchronously on rst.
- While rst=1, all outputs are 0, the dispatch FSM is in D_IDLE, and the round-robin pointer last_grant = ALU, so MUL wins the first tie.
- Dispatch FSM states: D_IDLE, D_MUL, D_ALU, D_DROP. Transitions:
  - D_IDLE, in_empty=0: in_op=10 -> D_MUL; 00/01 -> D_ALU; 11 -> D_DROP.
  - D_IDLE, in_empty=1: stay in D_IDLE.
  - D_MUL: mul_go = mul_ready & !mul_accept.
  - D_MUL, mul_accept=1: in_rd_en=1 in the same cycle -> D_IDLE.
  - D_ALU: alu_go = !alu_accept.
  - D_ALU, alu_accept=1: in_rd_en=1 in the same cycle -> D_IDLE.
  - D_DROP: in_rd_en=1, op_err=1 for one cycle -> D_IDLE.
- Dispatch is strictly in order, with head-of-line blocking: a pending MUL stalls later ADDs.
- Minimum of 2 cycles per dispatched operation, because D_IDLE is always re-entered.
- Units latch operands directly from the FIFO head; the scheduler never registers operands.
- An accept pulse arriving in any state other than its matching D_MUL/D_ALU is ignored: no pop, no state change.
- Writeback arbiter (combinational grant, registered pointer):
  - out_full=1: no grant; out_wr_en=0 and both written signals are 0. Pending valids are held by the units.
  - Exactly one valid: grant it.
  - Both valid: grant the unit that is not last_grant. last_grant updates on every grant.
  - On grant: out_wr_en=1, out_data = the granted result, and the granted unit's *_written=1, all in the same cycle. The other unit's written stays 0.
  - Latency from valid to write is 0 cycles when uncontended and the FIFO is not full.
  - Worst-case wait while out_full=0: 1 cycle (no starvation).
- No grant when neither valid is asserted; out_data = 0 when out_wr_en=0.
- Dispatch and writeback run independently in the same cycle. A pop and a write in the same cycle are legal.
- Reset mid-operation:
  - The FSM aborts to D_IDLE without popping; the head entry is re-dispatched after reset.
  - The units are reset by their own rst_n (= !rst) at top level.

Optional Feature:
- Macro: ALU_SCHED_STATS_EN.
- Defined: adds outputs mul_cnt[15:0], alu_cnt[15:0] and drop_cnt[15:0].
  - mul_cnt and alu_cnt increment on mul_written and alu_written respectively.
  - drop_cnt increments on op_err.
  - All three saturate at 16'hFFFF and clear on rst.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package alu_ctrl_pkg: OP_ADD/OP_SUB/OP_MUL/OP_RSVD constants, dispatch state encodings D_IDLE..D_DROP, RES_W computation.
- One sub-module, wb_rr_arbiter: 2-requester round-robin arbiter with a full-gate input, grant vector output and internal last_grant register.
- The dispatch FSM stays in alu_op_scheduler.

Test Plan:
- MUL dispatch: head in_op=10, mul_ready=1, mul_accept on cycle 3 -> mul_go high in cycles 2-3 (low when mul_accept=1); in_rd_en pulse in cycle 3; D_IDLE in cycle 4.
- Contention:
  - Setup: mul_valid_res=1 and alu_valid_res=1 held for 3 cycles, out_full=0, after reset.
  - Required writes: MUL, ALU, MUL; out_data matches each granted result; written pulses alternate.
- Backpressure: out_full=1 for 4 cycles with mul_valid_res=1 -> out_wr_en=0, mul_written=0; on out_full=0, write occurs in that same cycle.
- Reserved opcode: in_op=11 -> op_err=1 and in_rd_en=1 for exactly one cycle; no mul_go or alu_go; with ALU_SCHED_STATS_EN, drop_cnt=1.
- Head-of-line blocking: FIFO holds MUL then ADD, mul_ready=0 for 10 cycles -> alu_go stays 0 and no pop, until mul_accept.
- Reset mid-dispatch: rst=1 while in D_ALU before alu_accept -> no pop, all outputs 0; after release the same head is re-dispatched (alu_go=1 within 2 cycles).
